comb_pipe_test: RTL and testbench

//  Clocked, parametrised successor of the comb_test systest block. Computes the same

---
 rtl/comb_pipe_test_if.sv | 30 +++
 rtl/comb_pipe_test.sv | 130 +++++++++++++
 tb/tb_comb_pipe_test.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comb_pipe_test_if.sv
// Handshake and data bundle for comb_pipe_test: upstream valid/ready with three
// operands, downstream valid/ready with five result fields.
interface comb_pipe_test_if #(
   parameter int size = 1
);
   logic            in_valid;
   logic            in_ready;
   logic [size-1:0] src1;
   logic [size-1:0] src2;
   logic [size-1:0] src3;
   logic            out_valid;
   logic            out_ready;
   logic [size-1:0] out1;
   logic [size-1:0] out2;
   logic [size-1:0] out3;
   logic [size-1:0] out4;
   logic [size-1:0] out5;

   // Producer/consumer side (testbench or surrounding logic)
   modport master (
      output in_valid, src1, src2, src3, out_ready,
      input  in_ready, out_valid, out1, out2, out3, out4, out5
   );

   // Pipeline side
   modport slave (
      input  in_valid, src1, src2, src3, out_ready,
      output in_ready, out_valid, out1, out2, out3, out4, out5
   );
endinterface

// File: rtl/comb_pipe_test.sv
// comb_pipe_test: computes pass-through, compare-select, 3-bit decode, running
// accumulator and beat counter fields for each accepted beat and carries them
// through a DEPTH-stage elastic valid/ready pipeline.
// Optional feature: define COMB_PIPE_TEST_SAT_EN to make the accumulator
// saturate at 2^size-1 and the beat counter stop at 2^size-1 instead of wrapping.
module comb_pipe_test #(
   parameter int size  = 1,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   comb_pipe_test_if.slave    bus
);

   // Field order inside a beat: [0]=f1 .. [4]=f5
   typedef logic [4:0][size-1:0] beat_t;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] v_in;
   beat_t            stg_q [DEPTH];
   beat_t            stg_d [DEPTH];
   beat_t            d_in  [DEPTH];
   beat_t            new_beat;
   logic [size-1:0]  acc_q, acc_d, acc_nxt;
   logic [size-1:0]  cnt_q, cnt_d, cnt_nxt;
   logic             accept;

   function automatic logic [size-1:0] add_acc(input logic [size-1:0] a,
                                               input logic [size-1:0] b);
      logic [size:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef COMB_PIPE_TEST_SAT_EN
      return s[size] ? {size{1'b1}} : s[size-1:0];
`else
      return s[size-1:0];
`endif
   endfunction

   function automatic logic [size-1:0] inc_cnt(input logic [size-1:0] c);
`ifdef COMB_PIPE_TEST_SAT_EN
      return (&c) ? c : c + size'(1);
`else
      return c + size'(1);
`endif
   endfunction

   // The decode is 3 bits wide; narrow datapaths keep the low bits, wide ones zero-extend.
   function automatic logic [size-1:0] fit3(input logic [2:0] v);
      logic [63:0] w;
      w = {61'd0, v};
      return w[size-1:0];
   endfunction

   // Result fields of the beat presented at the input this cycle
   always_comb begin
      acc_nxt     = add_acc(acc_q, bus.src1);
      cnt_nxt     = inc_cnt(cnt_q);
      new_beat[0] = bus.src1;
      new_beat[1] = (bus.src1 < bus.src2) ? bus.src1 : bus.src3;
      new_beat[2] = fit3(3'd7 - {bus.src1[0], bus.src2[0], bus.src3[0]});
      new_beat[3] = acc_nxt;
      new_beat[4] = cnt_nxt;
   end

   // Load chain: a stage loads when empty or when the stage after it moves on
   always_comb begin
      logic chain;
      chain = bus.out_ready;
      load  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         chain   = chain | ~valid_q[k];
         load[k] = chain;
      end
   end

   assign bus.in_ready = load[0];
   assign accept       = bus.in_valid & load[0];

   // What each stage would receive: the new beat for stage 0, the previous stage otherwise
   always_comb begin
      v_in[0] = accept;
      d_in[0] = new_beat;
      for (int k = 1; k < DEPTH; k++) begin
         v_in[k] = valid_q[k-1];
         d_in[k] = stg_q[k-1];
      end
   end

   // Next state: stage data only changes when a real beat arrives, so bubbles keep old contents
   always_comb begin
      valid_d = valid_q;
      stg_d   = stg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (accept) begin
         acc_d = acc_nxt;
         cnt_d = cnt_nxt;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (load[k]) begin
            valid_d[k] = v_in[k];
            if (v_in[k]) stg_d[k] = d_in[k];
         end
      end
   end

   // State registers; reset clears every stage, so in-flight beats are discarded
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < DEPTH; k++) stg_q[k] <= '0;
      end else begin
         valid_q <= valid_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         stg_q   <= stg_d;
      end
   end

   assign bus.out_valid = valid_q[DEPTH-1];
   assign bus.out1      = stg_q[DEPTH-1][0];
   assign bus.out2      = stg_q[DEPTH-1][1];
   assign bus.out3      = stg_q[DEPTH-1][2];
   assign bus.out4      = stg_q[DEPTH-1][3];
   assign bus.out5      = stg_q[DEPTH-1][4];

endmodule

// File: tb/tb_comb_pipe_test.sv
// Testbench for comb_pipe_test: main instance size=4/DEPTH=2 checked every cycle
// against a transaction-level queue model; a second size=1/DEPTH=1 instance
// covers the minimum configuration. Honours COMB_PIPE_TEST_SAT_EN if defined.
module tb_comb_pipe_test;
   localparam int SZ    = 4;
   localparam int DEPTH = 2;
   localparam int MAXV  = (1 << SZ) - 1;

   logic clk = 1'b0;
   logic reset;

   comb_pipe_test_if #(.size(SZ)) bus ();
   comb_pipe_test_if #(.size(1))  bus1 ();

   comb_pipe_test #(.size(SZ), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
   comb_pipe_test #(.size(1),  .DEPTH(1))     dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int f1, f2, f3, f4, f5;
   } mbeat_t;

   mbeat_t q[$];
   int     acc_m = 0;
   int     cnt_m = 0;
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   logic   last_acc;
   int     sent;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic mbeat_t make_beat(input int s1, input int s2, input int s3, input int t);
      mbeat_t b;
      int sum;
      sum = acc_m + s1;
`ifdef COMB_PIPE_TEST_SAT_EN
      acc_m = (sum > MAXV) ? MAXV : sum;
      cnt_m = (cnt_m == MAXV) ? MAXV : cnt_m + 1;
`else
      acc_m = sum % (MAXV + 1);
      cnt_m = (cnt_m + 1) % (MAXV + 1);
`endif
      b.t  = t;
      b.f1 = s1;
      b.f2 = (s1 < s2) ? s1 : s3;
      b.f3 = 7 - ((s1 % 2) * 4 + (s2 % 2) * 2 + (s3 % 2));
      b.f4 = acc_m;
      b.f5 = cnt_m;
      return b;
   endfunction

   // One clock: check at negedge against the model, account for handshakes, advance.
   task automatic tick();
      logic   was_rst;
      logic   emit;
      logic   exp_ov;
      mbeat_t h;
      @(negedge clk);
      was_rst  = reset;
      last_acc = 1'b0;
      if (!was_rst) begin
         chk("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || (q.size() < DEPTH)));
         exp_ov = (q.size() > 0) && ((cyc - q[0].t) >= DEPTH);
         chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
         if (bus.out_valid && q.size() > 0) begin
            h = q[0];
            chk("out1", 64'(bus.out1), 64'(h.f1));
            chk("out2", 64'(bus.out2), 64'(h.f2));
            chk("out3", 64'(bus.out3), 64'(h.f3));
            chk("out4", 64'(bus.out4), 64'(h.f4));
            chk("out5", 64'(bus.out5), 64'(h.f5));
         end
         emit     = bus.out_valid && bus.out_ready;
         last_acc = bus.in_valid && bus.in_ready;
         if (emit && q.size() > 0) void'(q.pop_front());
         if (last_acc) q.push_back(make_beat(int'(bus.src1), int'(bus.src2), int'(bus.src3), cyc));
      end
      @(posedge clk);
      cyc++;
      if (was_rst) begin
         q.delete();
         acc_m = 0;
         cnt_m = 0;
      end
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.src3      = '0;
      bus1.in_valid  = 1'b0;
      bus1.out_ready = 1'b1;
      bus1.src1      = '0;
      bus1.src2      = '0;
      bus1.src3      = '0;

      // T1: reset state
      tick();
      reset = 1'b0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out1", 64'(bus.out1), 64'd0);
      chk("rst_out2", 64'(bus.out2), 64'd0);
      chk("rst_out3", 64'(bus.out3), 64'd0);
      chk("rst_out4", 64'(bus.out4), 64'd0);
      chk("rst_out5", 64'(bus.out5), 64'd0);
      chk("rst1_out_valid", 64'(bus1.out_valid), 64'd0);

      // T2: single beat 3,5,9
      bus.src1 = 4'd3; bus.src2 = 4'd5; bus.src3 = 4'd9; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_out1", 64'(bus.out1), 64'd3);
      chk("t2_out2", 64'(bus.out2), 64'd3);
      chk("t2_out3", 64'(bus.out3), 64'd0);
      chk("t2_out4", 64'(bus.out4), 64'd3);
      chk("t2_out5", 64'(bus.out5), 64'd1);
      tick();
      chk("t2_single", 64'(bus.out_valid), 64'd0);

      // T3: beat 6,2,9
      bus.src1 = 4'd6; bus.src2 = 4'd2; bus.src3 = 4'd9; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("t3_out2", 64'(bus.out2), 64'd9);
      chk("t3_out3", 64'(bus.out3), 64'd6);
      chk("t3_out4", 64'(bus.out4), 64'd9);
      chk("t3_out5", 64'(bus.out5), 64'd2);
      tick();

      // T4: stall with four beats queued, then release
      sent = 0;
      bus.out_ready = 1'b0;
      for (int n = 0; n < 30 && sent < 4; n++) begin
         if (n == 5) begin
            chk("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t4_stall_out1", 64'(bus.out1), 64'd1);
            bus.out_ready = 1'b1;
         end
         bus.src1 = 4'(sent + 1); bus.src2 = 4'(n); bus.src3 = 4'(15 - n);
         bus.in_valid = 1'b1;
         tick();
         if (last_acc) sent++;
      end
      chk("t4_sent", 64'(sent), 64'd4);
      bus.in_valid = 1'b0;
      for (int n = 0; n < 4; n++) tick();

      // T5: wrap / saturation from a fresh reset, 17 beats of 15
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int n = 0; n < 17; n++) begin
         bus.src1 = 4'd15; bus.src2 = 4'($urandom_range(0, 15)); bus.src3 = 4'($urandom_range(0, 15));
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
`ifdef COMB_PIPE_TEST_SAT_EN
      chk("t5_out5_17", 64'(bus.out5), 64'd15);
      chk("t5_out4_17", 64'(bus.out4), 64'd15);
`else
      chk("t5_out5_17", 64'(bus.out5), 64'd1);
      chk("t5_out4_17", 64'(bus.out4), 64'd15);
`endif

      // T6: reset with two beats in flight, accept attempt during reset ignored
      bus.src1 = 4'd7; bus.in_valid = 1'b1;
      tick();
      bus.src1 = 4'd8;
      tick();
      reset = 1'b1;
      bus.src1 = 4'd9;
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      chk("t6_flush", 64'(bus.out_valid), 64'd0);
      tick();
      bus.src1 = 4'd5; bus.src2 = 4'd0; bus.src3 = 4'd0; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int n = 0; n < 5 && !bus.out_valid; n++) tick();
      chk("t6_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t6_out4", 64'(bus.out4), 64'd5);
      chk("t6_out5", 64'(bus.out5), 64'd1);
      tick();

      // Randomised traffic with random back-pressure
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.src1 = 4'($urandom_range(0, 15));
         bus.src2 = 4'($urandom_range(0, 15));
         bus.src3 = 4'($urandom_range(0, 15));
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 6; n++) tick();
      chk("drain_empty", 64'(bus.out_valid), 64'd0);

      // size=1, DEPTH=1: T2 pattern, latency 1
      bus1.src1 = 1'b1; bus1.src2 = 1'b1; bus1.src3 = 1'b1; bus1.in_valid = 1'b1;
      @(negedge clk);
      chk("s1_in_ready", 64'(bus1.in_ready), 64'd1);
      chk("s1_pre_valid", 64'(bus1.out_valid), 64'd0);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      @(negedge clk);
      chk("s1_out_valid", 64'(bus1.out_valid), 64'd1);
      chk("s1_out1", 64'(bus1.out1), 64'd1);
      chk("s1_out2", 64'(bus1.out2), 64'd1);
      chk("s1_out3", 64'(bus1.out3), 64'd0);
      chk("s1_out4", 64'(bus1.out4), 64'd1);
      chk("s1_out5", 64'(bus1.out5), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s1_single", 64'(bus1.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
